fifo_rd_stream: RTL and testbench

Read-side drain engine for the dual-clock FIFO. It sits in the read clock domain and pops words through the FIFO read port (`fifo_rd_en` / `fifo_dout` / `fifo_empty`). It re-presents those words as a registered valid/ready stream, with `m_last` marking every `BURST_LEN`-th beat. A 2-entry skid buffer gives full throughput without a combinational path from `m_ready` to `fifo_rd_en`.

---
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 tb/tb_fifo_rd_stream.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pops a show-ahead FIFO into a registered valid/ready
// stream through a 2-entry skid buffer. Optional stat counters: FIFO_RD_STREAM_STAT_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           burst_cnt
`ifdef FIFO_RD_STREAM_STAT_EN
  ,
  output logic [31:0]           beat_total,
  output logic [31:0]           stall_cnt
`endif
);

  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);
  localparam logic [1:0]  OCC_0     = 2'd0;
  localparam logic [1:0]  OCC_1     = 2'd1;
  localparam logic [1:0]  OCC_2     = 2'd2;

  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] slot0, slot1;
  logic [15:0]           beat;
  logic                  pop, hs;

  // Gated by rst so a word at the FIFO head is not popped and lost while held in reset.
  assign fifo_rd_en = en & ~fifo_empty & (occ != OCC_2) & ~rst;
  assign pop        = fifo_rd_en;
  assign m_valid    = (occ != OCC_0);
  assign hs         = m_valid & m_ready;
  assign m_data     = slot0;
  assign m_last     = m_valid & (beat == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ   <= OCC_0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (occ)
        OCC_0: if (pop) begin
          slot0 <= fifo_dout;
          occ   <= OCC_1;
        end
        OCC_1: begin
          if (pop && hs) begin
            slot0 <= fifo_dout;
          end else if (pop) begin
            slot1 <= fifo_dout;
            occ   <= OCC_2;
          end else if (hs) begin
            occ   <= OCC_0;
          end
        end
        OCC_2: if (hs) begin
          slot0 <= slot1;
          occ   <= OCC_1;
        end
        default: occ <= OCC_0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      burst_cnt <= '0;
    end else if (hs) begin
      if (m_last) begin
        beat      <= '0;
        burst_cnt <= burst_cnt + 16'd1;
      end else begin
        beat      <= beat + 16'd1;
      end
    end
  end

`ifdef FIFO_RD_STREAM_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_total <= '0;
      stall_cnt  <= '0;
    end else begin
      if (hs) beat_total <= beat_total + 32'd1;
      if (m_valid && !m_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO and scoreboard model, randomized
// backpressure, plus a BURST_LEN=1 instance sharing the same stimulus.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int BL = 16;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, fifo_empty = 1'b1, m_ready = 1'b0;
  logic [DW-1:0] fifo_dout = '0;

  logic          fifo_rd_en, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic [15:0]   burst_cnt;
  logic          fifo_rd_en1, m_valid1, m_last1;
  logic [DW-1:0] m_data1;
  logic [15:0]   burst_cnt1;
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [31:0]   beat_total, stall_cnt, beat_total1, stall_cnt1;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .burst_cnt(burst_cnt)
`ifdef FIFO_RD_STREAM_STAT_EN
    , .beat_total(beat_total), .stall_cnt(stall_cnt)
`endif
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en1), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_last(m_last1), .burst_cnt(burst_cnt1)
`ifdef FIFO_RD_STREAM_STAT_EN
    , .beat_total(beat_total1), .stall_cnt(stall_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int hs_total = 0, stall_total = 0, cyc = 0;
  logic [DW-1:0] fifo_q[$];   // words still in the FIFO
  logic [DW-1:0] exp_q[$];    // words popped but not yet accepted downstream
  bit  acc_last[$], acc_last1[$];
  int  acc_cyc[$];
  bit  prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? DW'($urandom) : fifo_q[0];
  endtask

  task automatic load(input int n, input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? DW'($urandom) : base + DW'(i));
    refresh();
  endtask

  task automatic clear_model();
    exp_q.delete(); acc_last.delete(); acc_last1.delete(); acc_cyc.delete();
    hs_total = 0; stall_total = 0; prev_stall = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance model past the edge.
  task automatic tick();
    bit exp_v, exp_rd, pop, hs, obs_last, obs_last1;
    @(negedge clk);
    exp_v  = (exp_q.size() != 0);
    exp_rd = en & ~rst & (fifo_q.size() != 0) & (exp_q.size() < 2);
    n_cmp++; if (fifo_rd_en !== exp_rd) begin n_err++; $display("FAIL rd_en cyc=%0d got %b exp %b", cyc, fifo_rd_en, exp_rd); end
    n_cmp++; if (m_valid !== exp_v) begin n_err++; $display("FAIL m_valid cyc=%0d got %b exp %b", cyc, m_valid, exp_v); end
    n_cmp++; if (m_last !== (exp_v && (hs_total % BL) == BL - 1)) begin n_err++; $display("FAIL m_last cyc=%0d got %b beat_idx %0d", cyc, m_last, hs_total); end
    n_cmp++; if (burst_cnt !== 16'(hs_total / BL)) begin n_err++; $display("FAIL burst_cnt cyc=%0d got %0d exp %0d", cyc, burst_cnt, hs_total / BL); end
    if (exp_v) begin
      n_cmp++; if (m_data !== exp_q[0]) begin n_err++; $display("FAIL m_data cyc=%0d got %h exp %h", cyc, m_data, exp_q[0]); end
      n_cmp++; if (m_data1 !== exp_q[0]) begin n_err++; $display("FAIL m_data1 cyc=%0d got %h exp %h", cyc, m_data1, exp_q[0]); end
    end
    n_cmp++; if ({fifo_rd_en1, m_valid1, m_last1} !== {exp_rd, exp_v, exp_v}) begin
      n_err++; $display("FAIL bl1_ctl cyc=%0d got %b exp %b", cyc, {fifo_rd_en1, m_valid1, m_last1}, {exp_rd, exp_v, exp_v}); end
    n_cmp++; if (burst_cnt1 !== 16'(hs_total)) begin n_err++; $display("FAIL bl1_burst_cnt cyc=%0d got %0d exp %0d", cyc, burst_cnt1, hs_total); end
    if (prev_stall) begin
      n_cmp++; if (m_data !== prev_data || m_last !== prev_last) begin
        n_err++; $display("FAIL stall_stable cyc=%0d got %h/%b exp %h/%b", cyc, m_data, m_last, prev_data, prev_last); end
    end
`ifdef FIFO_RD_STREAM_STAT_EN
    n_cmp++; if (beat_total !== 32'(hs_total)) begin n_err++; $display("FAIL beat_total cyc=%0d got %0d exp %0d", cyc, beat_total, hs_total); end
    n_cmp++; if (stall_cnt !== 32'(stall_total)) begin n_err++; $display("FAIL stall_cnt cyc=%0d got %0d exp %0d", cyc, stall_cnt, stall_total); end
`endif
    pop = exp_rd;
    hs  = exp_v & m_ready & ~rst;
    obs_last = m_last; obs_last1 = m_last1;
    prev_stall = exp_v & ~m_ready & ~rst;
    prev_data = m_data; prev_last = m_last;
    @(posedge clk); #1;
    if (hs) begin
      void'(exp_q.pop_front());
      acc_last.push_back(obs_last); acc_last1.push_back(obs_last1); acc_cyc.push_back(cyc);
      hs_total++;
    end
    if (pop) exp_q.push_back(fifo_q.pop_front());
    if (prev_stall) stall_total++;
    cyc++;
    refresh();
  endtask

  task automatic apply_reset();
    rst = 1'b1; clear_model();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int b = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && b < budget) begin tick(); b++; end
    n_cmp++; if (b >= budget) begin n_err++; $display("FAIL drain_timeout got %0d left exp 0", fifo_q.size() + exp_q.size()); end
  endtask

  task automatic test_reset();
    fifo_q.delete(); load(3, 32'hC0DE_0000, 1'b0);
    en = 1'b1; m_ready = 1'b0;
    apply_reset();
    rst = 1'b1; #1;
    n_cmp++; if ({fifo_rd_en, m_valid, m_last} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got %b exp 000", {fifo_rd_en, m_valid, m_last}); end
    n_cmp++; if (m_data !== '0 || burst_cnt !== '0) begin n_err++; $display("FAIL reset_data got %h/%0d exp 0/0", m_data, burst_cnt); end
    rst = 1'b0; #1;
    n_cmp++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("FAIL first_pop got %b exp 1", fifo_rd_en); end
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'hC0DE_0000) begin
      n_err++; $display("FAIL first_latency got %b/%h exp 1/c0de0000", m_valid, m_data); end
    m_ready = 1'b1;
    run_until_done(50);
  endtask

  task automatic test_stream64();
    int gaps = 0;
    apply_reset();
    fifo_q.delete(); load(64, 32'h1A2B_0000, 1'b0);
    en = 1'b1; m_ready = 1'b1;
    run_until_done(200);
    n_cmp++; if (acc_cyc.size() != 64) begin n_err++; $display("FAIL s64_count got %0d exp 64", acc_cyc.size()); end
    else begin
      for (int i = 1; i < 64; i++) if (acc_cyc[i] != acc_cyc[0] + i) gaps++;
      n_cmp++; if (gaps != 0) begin n_err++; $display("FAIL s64_gaps got %0d exp 0", gaps); end
      for (int i = 0; i < 64; i++) begin
        n_cmp++; if (acc_last[i] != ((i % 16) == 15)) begin n_err++; $display("FAIL s64_last i=%0d got %b exp %b", i, acc_last[i], (i % 16) == 15); end
      end
    end
    n_cmp++; if (burst_cnt !== 16'd4) begin n_err++; $display("FAIL s64_bursts got %0d exp 4", burst_cnt); end
  endtask

  task automatic test_backpressure();
    int b = 0;
    apply_reset();
    fifo_q.delete(); load(20, '0, 1'b1);
    en = 1'b1;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && b < 500) begin
      m_ready = 1'($urandom_range(0, 1)); tick(); b++;
    end
    n_cmp++; if (acc_cyc.size() != 20) begin n_err++; $display("FAIL bp_count got %0d exp 20", acc_cyc.size()); end
    n_cmp++; if (burst_cnt !== 16'd1) begin n_err++; $display("FAIL bp_bursts got %0d exp 1", burst_cnt); end
    m_ready = 1'b1;
  endtask

  task automatic test_en_drop();
    int b = 0, h0;
    apply_reset();
    fifo_q.delete(); load(32, 32'h5E00_0000, 1'b0);
    en = 1'b1; m_ready = 1'b1;
    while (hs_total < 5 && b < 50) begin tick(); b++; end
    en = 1'b0; h0 = hs_total;
    repeat (10) tick();
    n_cmp++; if (hs_total - h0 > 2) begin n_err++; $display("FAIL en_extra got %0d exp <=2", hs_total - h0); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL en_drained got %b exp 0", m_valid); end
    en = 1'b1;
    run_until_done(200);
    n_cmp++; if (acc_last.size() != 32) begin n_err++; $display("FAIL en_count got %0d exp 32", acc_last.size()); end
    else begin
      n_cmp++; if ({acc_last[14], acc_last[15], acc_last[31]} != 3'b011) begin
        n_err++; $display("FAIL en_last got %b exp 011", {acc_last[14], acc_last[15], acc_last[31]}); end
    end
    n_cmp++; if (burst_cnt !== 16'd2) begin n_err++; $display("FAIL en_bursts got %0d exp 2", burst_cnt); end
  endtask

  task automatic test_burst_len1();
    int ones = 0;
    apply_reset();
    fifo_q.delete(); load(8, 32'h0B1B_0000, 1'b0);
    en = 1'b1; m_ready = 1'b1;
    run_until_done(50);
    foreach (acc_last1[i]) if (acc_last1[i]) ones++;
    n_cmp++; if (ones != 8) begin n_err++; $display("FAIL bl1_lasts got %0d exp 8", ones); end
    n_cmp++; if (burst_cnt1 !== 16'd8) begin n_err++; $display("FAIL bl1_bursts got %0d exp 8", burst_cnt1); end
  endtask

`ifdef FIFO_RD_STREAM_STAT_EN
  task automatic test_stat();
    int b = 0;
    apply_reset();
    fifo_q.delete(); load(10, 32'h57A7_0000, 1'b1);
    en = 1'b1; m_ready = 1'b0;
    while (m_valid !== 1'b1 && b < 20) begin tick(); b++; end
    repeat (7) tick();
    m_ready = 1'b1;
    run_until_done(100);
    n_cmp++; if (stall_cnt !== 32'd7) begin n_err++; $display("FAIL stat_stall got %0d exp 7", stall_cnt); end
    n_cmp++; if (beat_total !== 32'd10) begin n_err++; $display("FAIL stat_beats got %0d exp 10", beat_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream64();
    test_backpressure();
    test_en_drop();
    test_burst_len1();
`ifdef FIFO_RD_STREAM_STAT_EN
    test_stat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
